// File: rtl/move_responder_if.sv
// rtl/move_responder_if.sv - move/store request bundle between the game control FSM and the responder
interface move_responder_if;
   logic [3:0] code;
   logic       move;
   logic       store;
   logic       move_able;

   modport master (output code, output move, output store, input move_able);
   modport slave  (input code, input move, input store, output move_able);
endinterface

// File: rtl/move_responder.sv
// rtl/move_responder.sv - player position datapath answering FSM move/store requests
module move_responder #(
   parameter int GRID_W = 8,
   parameter int GRID_H = 8,
   parameter int XW = 3,
   parameter int YW = 3,
   parameter int START_X = 0,
   parameter int START_Y = 0,
   parameter int GOAL_X = 7,
   parameter int GOAL_Y = 7,
   parameter logic [GRID_W*GRID_H-1:0] WALL_MAP = '0,
   parameter int STEP_W = 10
) (
   input  logic              clk,
   input  logic              clr,
   move_responder_if.slave   bus,
   output logic [XW-1:0]     pos_x,
   output logic [YW-1:0]     pos_y,
   output logic [STEP_W-1:0] steps,
   output logic              win,
   output logic              bump,
   output logic              proto_err
);

   localparam int CELLS = GRID_W * GRID_H;
   localparam int IW = (CELLS > 1) ? $clog2(CELLS) : 1;

   localparam logic [3:0] CODE_U = 4'b0001;
   localparam logic [3:0] CODE_D = 4'b0010;
   localparam logic [3:0] CODE_L = 4'b0100;
   localparam logic [3:0] CODE_R = 4'b1000;

   logic [XW-1:0]     pos_x_q, pos_x_d;
   logic [YW-1:0]     pos_y_q, pos_y_d;
   logic [XW-1:0]     cand_x_q, cand_x_d;
   logic [YW-1:0]     cand_y_q, cand_y_d;
   logic              pend_q, pend_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic              win_q, win_d;
   logic              bump_q, bump_d;
   logic              proto_err_q, proto_err_d;

   logic [XW-1:0] tgt_x;
   logic [YW-1:0] tgt_y;
   logic          in_bounds;
   logic [IW-1:0] cell_idx;
   logic          wall_hit;
   logic          able;

   // Edge tests come before the +/-1 so a move off the board never wraps.
   // Illegal codes (zero or multi-hot) fall into the default and stay out of bounds.
   always_comb begin
      tgt_x     = pos_x_q;
      tgt_y     = pos_y_q;
      in_bounds = 1'b0;
      case (bus.code)
         CODE_U: begin
            in_bounds = (pos_y_q != '0);
            tgt_y     = pos_y_q - YW'(1);
         end
         CODE_D: begin
            in_bounds = (pos_y_q != YW'(GRID_H - 1));
            tgt_y     = pos_y_q + YW'(1);
         end
         CODE_L: begin
            in_bounds = (pos_x_q != '0);
            tgt_x     = pos_x_q - XW'(1);
         end
         CODE_R: begin
            in_bounds = (pos_x_q != XW'(GRID_W - 1));
            tgt_x     = pos_x_q + XW'(1);
         end
         default: in_bounds = 1'b0;
      endcase
   end

   always_comb begin
      cell_idx = IW'(tgt_y) * IW'(GRID_W) + IW'(tgt_x);
      wall_hit = in_bounds & WALL_MAP[cell_idx];
      able     = bus.move & in_bounds & ~wall_hit & ~win_q & ~pend_q;
   end

   assign bus.move_able = able;

   always_comb begin
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      cand_x_d    = cand_x_q;
      cand_y_d    = cand_y_q;
      pend_d      = pend_q;
      steps_d     = steps_q;
      win_d       = win_q;
      proto_err_d = proto_err_q;
      bump_d      = bus.move & ~able & ~pend_q;

      if (bus.store) begin
         if (pend_q) begin
            pos_x_d = cand_x_q;
            pos_y_d = cand_y_q;
            pend_d  = 1'b0;
            if (steps_q != '1) begin
               steps_d = steps_q + STEP_W'(1);
            end
            if (cand_x_q == XW'(GOAL_X) && cand_y_q == YW'(GOAL_Y)) begin
               win_d = 1'b1;
            end
         end else begin
            proto_err_d = 1'b1;
         end
      end

      // Candidate is captured now because code may change before store arrives.
      if (able) begin
         cand_x_d = tgt_x;
         cand_y_d = tgt_y;
         pend_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pos_x_q     <= XW'(START_X);
         pos_y_q     <= YW'(START_Y);
         cand_x_q    <= '0;
         cand_y_q    <= '0;
         pend_q      <= 1'b0;
         steps_q     <= '0;
         win_q       <= 1'b0;
         bump_q      <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         cand_x_q    <= cand_x_d;
         cand_y_q    <= cand_y_d;
         pend_q      <= pend_d;
         steps_q     <= steps_d;
         win_q       <= win_d;
         bump_q      <= bump_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign pos_x     = pos_x_q;
   assign pos_y     = pos_y_q;
   assign steps     = steps_q;
   assign win       = win_q;
   assign bump      = bump_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_move_responder.sv
// tb/tb_move_responder.sv - directed scoreboard bench for move_responder
module tb_move_responder;

   localparam logic [3:0] U = 4'b0001;
   localparam logic [3:0] D = 4'b0010;
   localparam logic [3:0] L = 4'b0100;
   localparam logic [3:0] R = 4'b1000;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [2:0] pos_x;
   logic [2:0] pos_y;
   logic [9:0] steps;
   logic       win;
   logic       bump;
   logic       proto_err;

   move_responder_if bus ();

   move_responder #(
      .GRID_W(8), .GRID_H(8), .XW(3), .YW(3),
      .START_X(0), .START_Y(0), .GOAL_X(7), .GOAL_Y(7),
      .WALL_MAP(64'h0000_0000_0000_0004), .STEP_W(10)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus),
      .pos_x(pos_x),
      .pos_y(pos_y),
      .steps(steps),
      .win(win),
      .bump(bump),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int able;
      int x;
      int y;
      int st;
      int w;
      int b;
      int e;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   vec_no = 0;

   task automatic chk(input string name, input int idx, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL vec%0d %s: got %0d expected %0d", idx, name, act, exp);
      end
   endtask

   // Monitor: inputs settle 1ns after posedge, outputs are sampled on the falling edge.
   int mon_idx = 0;
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("move_able", mon_idx, int'(bus.move_able), e.able);
         chk("pos_x", mon_idx, int'(pos_x), e.x);
         chk("pos_y", mon_idx, int'(pos_y), e.y);
         chk("steps", mon_idx, int'(steps), e.st);
         chk("win", mon_idx, int'(win), e.w);
         chk("bump", mon_idx, int'(bump), e.b);
         chk("proto_err", mon_idx, int'(proto_err), e.e);
         mon_idx++;
      end
   end

   task automatic vec(input logic c, input logic [3:0] cd, input logic mv, input logic st,
                      input int ea, input int ex, input int ey, input int es,
                      input int ew, input int eb, input int ee);
      exp_t e;
      @(posedge clk);
      #1;
      clr       = c;
      bus.code  = cd;
      bus.move  = mv;
      bus.store = st;
      e.able = ea; e.x = ex; e.y = ey; e.st = es; e.w = ew; e.b = eb; e.e = ee;
      sb.push_back(e);
      vec_no++;
   endtask

   initial begin
      int x;
      int y;
      int s;
      bus.code  = 4'b0000;
      bus.move  = 1'b0;
      bus.store = 1'b0;

      //   clr code mv st | able x y steps win bump err
      vec(1, 4'b0000, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      vec(0, R,       1, 0,  1, 0, 0, 0, 0, 0, 0);
      vec(0, 4'b0000, 0, 1,  0, 0, 0, 0, 0, 0, 0);
      vec(0, 4'b0000, 0, 0,  0, 1, 0, 1, 0, 0, 0);
      // up from the top row is refused, bump for one cycle
      vec(0, U,       1, 0,  0, 1, 0, 1, 0, 0, 0);
      vec(0, 4'b0000, 0, 0,  0, 1, 0, 1, 0, 1, 0);
      vec(0, 4'b0000, 0, 0,  0, 1, 0, 1, 0, 0, 0);
      // wall at (2,0)
      vec(0, R,       1, 0,  0, 1, 0, 1, 0, 0, 0);
      vec(0, D,       1, 0,  1, 1, 0, 1, 0, 1, 0);
      vec(0, L,       0, 1,  0, 1, 0, 1, 0, 0, 0);
      vec(0, 4'b0000, 0, 0,  0, 1, 1, 2, 0, 0, 0);
      // latched R survives a code change and a refused move while pending
      vec(0, R,       1, 0,  1, 1, 1, 2, 0, 0, 0);
      vec(0, L,       0, 0,  0, 1, 1, 2, 0, 0, 0);
      vec(0, L,       1, 0,  0, 1, 1, 2, 0, 0, 0);
      vec(0, L,       0, 1,  0, 1, 1, 2, 0, 0, 0);
      vec(0, 4'b0000, 0, 0,  0, 2, 1, 3, 0, 0, 0);
      // move and store together with nothing pending
      vec(0, R,       1, 1,  1, 2, 1, 3, 0, 0, 0);
      vec(0, 4'b0000, 0, 1,  0, 2, 1, 3, 0, 0, 1);
      vec(0, 4'b0000, 0, 0,  0, 3, 1, 4, 0, 0, 1);

      x = 3; y = 1; s = 4;
      for (int i = 0; i < 4; i++) begin
         vec(0, R,       1, 0, 1, x, y, s, 0, 0, 1);
         vec(0, 4'b0000, 0, 1, 0, x, y, s, 0, 0, 1);
         x++; s++;
      end
      for (int i = 0; i < 6; i++) begin
         vec(0, D,       1, 0, 1, x, y, s, 0, 0, 1);
         vec(0, 4'b0000, 0, 1, 0, x, y, s, 0, 0, 1);
         y++; s++;
      end
      vec(0, 4'b0000, 0, 0,  0, 7, 7, 14, 1, 0, 1);
      vec(0, U,       1, 0,  0, 7, 7, 14, 1, 0, 1);
      vec(0, 4'b0000, 0, 1,  0, 7, 7, 14, 1, 1, 1);
      vec(0, 4'b0000, 0, 0,  0, 7, 7, 14, 1, 0, 1);

      // reset between move and store drops the pending candidate
      vec(1, 4'b0000, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      vec(0, R,       1, 0,  1, 0, 0, 0, 0, 0, 0);
      vec(1, 4'b0000, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      vec(0, 4'b0000, 0, 1,  0, 0, 0, 0, 0, 0, 0);
      vec(0, 4'b0000, 0, 0,  0, 0, 0, 0, 0, 0, 1);
      vec(0, 4'b0101, 1, 0,  0, 0, 0, 0, 0, 0, 1);
      vec(0, 4'b0000, 0, 0,  0, 0, 0, 0, 0, 1, 1);
      vec(0, 4'b0000, 1, 0,  0, 0, 0, 0, 0, 0, 1);
      vec(0, 4'b0000, 0, 0,  0, 0, 0, 0, 0, 1, 1);

      for (int k = 0; k < 5 && sb.size() > 0; k++) begin
         @(negedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d entries left expected 0", sb.size());
      end
      if (mon_idx != vec_no) begin
         total++;
         bad++;
         $display("FAIL count: got %0d checked expected %0d", mon_idx, vec_no);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
